// File: rtl/inst_sram_resp_pkg.sv
// Shared types and constants for the inst-SRAM responder.
// The INST_SRAM_PARITY_EN macro enables per-lane parity in the array.
package inst_sram_resp_pkg;

    // Reset fetch address of the core; byte address of word 0 of the inst SRAM.
    localparam logic [31:0] INST_RESET_BASE = 32'hbfc00000;
    localparam int          LANES           = 4;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    // Even-parity bit per byte lane: byte plus its bit holds an even number of ones.
    function automatic logic [LANES-1:0] lane_parity(input logic [31:0] w);
        logic [LANES-1:0] p;
        for (int i = 0; i < LANES; i++) begin
            p[i] = ^w[8*i +: 8];
        end
        return p;
    endfunction

endpackage

// File: rtl/inst_sram_ram.sv
// Byte-enable word array: one synchronous read port, one write port, read-first.
// With INST_SRAM_PARITY_EN defined, an even-parity bit per lane is stored next to
// the data; wpar_inv flips the stored bits for fault injection.
module inst_sram_ram
    import inst_sram_resp_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic [LANES-1:0]  we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic [LANES-1:0]  wpar_inv,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rdata,
    output logic [LANES-1:0]  rpar
);

    localparam int DEPTH = 2**ADDR_W;

    logic [31:0] mem [DEPTH];

    // Data array: lane writes and registered read.
    // NOTE: the array has no reset so it maps onto block RAM; the parent's clear
    // sweep is what gives it known contents.
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (we[i]) begin
                // NOTE: non-blocking on both the write and the read below means the
                // read samples the pre-edge word, which is what makes the port read-first.
                mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

`ifdef INST_SRAM_PARITY_EN
    logic [LANES-1:0] par_mem [DEPTH];
    logic [LANES-1:0] wpar;

    assign wpar = lane_parity(wdata) ^ wpar_inv;

    // Parity array: written lane-for-lane with the data, read alongside it.
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (we[i]) begin
                par_mem[waddr][i] <= wpar[i];
            end
        end
        if (re) begin
            rpar <= par_mem[raddr];
        end
    end
`else
    logic unused_par_inv;

    assign unused_par_inv = ^wpar_inv;
    assign rpar           = '0;
`endif

endmodule

// File: rtl/inst_sram_resp.sv
// Responder for the fetch-stage inst-SRAM port: 1-cycle read latency, byte-lane
// writes, address-window check, post-reset zero sweep and a backdoor loader.
// Optional feature: define INST_SRAM_PARITY_EN for per-lane parity with par_err.
module inst_sram_resp
    import inst_sram_resp_pkg::*;
#(
    parameter int          ADDR_W         = 12,
    parameter logic [31:0] BASE           = INST_RESET_BASE,
    parameter int          CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              inst_sram_en,
    input  logic [3:0]        inst_sram_wen,
    input  logic [31:0]       inst_sram_addr,
    input  logic [31:0]       inst_sram_wdata,
    output logic [31:0]       inst_sram_rdata,
    output logic              oor_err,
    output logic              par_err,
    output logic              init_done,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_idx,
    input  logic [31:0]       ld_data,
    input  logic [3:0]        ld_par_inv
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              zero_q, zero_d;   // forces rdata to 0 (reset, clear, out-of-window)
    logic              oor_q, oor_d;
    logic              init_q;

    logic              hit;
    logic [ADDR_W-1:0] idx;

    logic [3:0]        wr_en;
    logic [ADDR_W-1:0] wr_idx;
    logic [31:0]       wr_data;
    logic [3:0]        wr_inv;
    logic              rd_en;
    logic [31:0]       ram_q;
    logic [3:0]        ram_par;

    logic              unused_addr_lsb;

    assign hit             = (inst_sram_addr[31:ADDR_W+2] == BASE[31:ADDR_W+2]);
    assign idx             = inst_sram_addr[ADDR_W+1:2];
    assign unused_addr_lsb = ^inst_sram_addr[1:0];

    // Next state, array port arbitration and response flags.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path can leave one
        // unassigned and infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        zero_d  = zero_q;
        oor_d   = 1'b0;
        wr_en   = '0;
        wr_idx  = cnt_q;
        wr_data = '0;
        wr_inv  = '0;
        rd_en   = 1'b0;

        unique case (state_q)
            ST_CLEAR: begin
                wr_en  = 4'hf;
                cnt_d  = cnt_q + ADDR_W'(1);
                zero_d = 1'b1;
                if (&cnt_q) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                if (inst_sram_en) begin
                    zero_d = !hit;
                    oor_d  = !hit;
                    rd_en  = hit;
                end
                // Loader owns the single write port whenever it is active.
                if (ld_en) begin
                    wr_en   = 4'hf;
                    wr_idx  = ld_idx;
                    wr_data = ld_data;
                    wr_inv  = ld_par_inv;
                end else if (inst_sram_en && hit) begin
                    wr_en   = inst_sram_wen;
                    wr_idx  = idx;
                    wr_data = inst_sram_wdata;
                end
            end
            default: ;
        endcase
    end

    // State register, clear counter and response flags.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
            cnt_q   <= '0;
            zero_q  <= 1'b1;
            oor_q   <= 1'b0;
            init_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            zero_q  <= zero_d;
            oor_q   <= oor_d;
            init_q  <= (state_d == ST_READY);
        end
    end

    inst_sram_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk      (clk),
        .we       (wr_en),
        .waddr    (wr_idx),
        .wdata    (wr_data),
        .wpar_inv (wr_inv),
        .re       (rd_en),
        .raddr    (idx),
        .rdata    (ram_q),
        .rpar     (ram_par)
    );

    assign inst_sram_rdata = zero_q ? '0 : ram_q;
    assign oor_err         = oor_q;
    assign init_done       = init_q;

`ifdef INST_SRAM_PARITY_EN
    logic chk_q;

    // Arms the parity check for the cycle after a READY read hit.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            chk_q <= 1'b0;
        end else begin
            chk_q <= (state_q == ST_READY) && inst_sram_en && hit && (inst_sram_wen == 4'h0);
        end
    end

    assign par_err = chk_q && (lane_parity(ram_q) != ram_par);
`else
    logic unused_ram_par;

    assign unused_ram_par = ^ram_par;
    assign par_err        = 1'b0;
`endif

endmodule

// File: tb/tb_inst_sram_resp.sv
// Directed bench for inst_sram_resp with ADDR_W=4, CLEAR_ON_RESET=1.
// Expected par_err follows INST_SRAM_PARITY_EN.
module tb_inst_sram_resp;

    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          resetn;
    logic          en;
    logic [3:0]    wen;
    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic [31:0]   rdata;
    logic          oor_err;
    logic          par_err;
    logic          init_done;
    logic          ld_en;
    logic [AW-1:0] ld_idx;
    logic [31:0]   ld_data;
    logic [3:0]    ld_par_inv;

    int total = 0;
    int bad   = 0;

`ifdef INST_SRAM_PARITY_EN
    localparam logic PAR_EXP = 1'b1;
`else
    localparam logic PAR_EXP = 1'b0;
`endif

    always #5 clk = ~clk;

    inst_sram_resp #(
        .ADDR_W         (AW),
        .BASE           (32'hbfc00000),
        .CLEAR_ON_RESET (1)
    ) dut (
        .clk             (clk),
        .resetn          (resetn),
        .inst_sram_en    (en),
        .inst_sram_wen   (wen),
        .inst_sram_addr  (addr),
        .inst_sram_wdata (wdata),
        .inst_sram_rdata (rdata),
        .oor_err         (oor_err),
        .par_err         (par_err),
        .init_done       (init_done),
        .ld_en           (ld_en),
        .ld_idx          (ld_idx),
        .ld_data         (ld_data),
        .ld_par_inv      (ld_par_inv)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are sampled 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_req(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
        en = 1'b1; wen = w; addr = a; wdata = d;
        tick();
        en = 1'b0; wen = 4'h0;
    endtask

    task automatic load(input logic [AW-1:0] i, input logic [31:0] d, input logic [3:0] inv);
        ld_en = 1'b1; ld_idx = i; ld_data = d; ld_par_inv = inv;
        tick();
        ld_en = 1'b0; ld_par_inv = 4'h0;
    endtask

    // Counts edges until init_done, flagging any response activity during the sweep.
    task automatic wait_init(input string tag);
        int n = 0;
        int noise = 0;
        while (init_done !== 1'b1 && n < 40) begin
            tick();
            n++;
            if (init_done !== 1'b1 && (rdata !== 32'h0 || oor_err !== 1'b0 || par_err !== 1'b0))
                noise++;
        end
        check({tag, "_len"}, n, 16);
        check({tag, "_quiet"}, noise, 0);
    endtask

    initial begin
        resetn = 1'b0; en = 1'b0; wen = 4'h0; addr = '0; wdata = '0;
        ld_en = 1'b0; ld_idx = '0; ld_data = '0; ld_par_inv = 4'h0;
        tick();
        tick();
        check("rst_rdata", rdata, 32'h0);
        check("rst_oor",   {31'h0, oor_err}, 32'h0);
        check("rst_par",   {31'h0, par_err}, 32'h0);
        check("rst_init",  {31'h0, init_done}, 32'h0);

        resetn = 1'b1;
        wait_init("clear");

        cpu_req(32'hbfc00008, 4'h0, 32'h0);
        check("rd_cleared", rdata, 32'h0);

        load(4'd0, 32'h3c1d0001, 4'h0);
        cpu_req(32'hbfc00000, 4'h0, 32'h0);
        check("rd_ld0", rdata, 32'h3c1d0001);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold", rdata, 32'h3c1d0001);
        end

        load(4'd1, 32'h11223344, 4'h0);
        cpu_req(32'hbfc00004, 4'b0011, 32'haabbccdd);
        check("wr_read_first", rdata, 32'h11223344);
        cpu_req(32'hbfc00004, 4'h0, 32'h0);
        check("wr_merged", rdata, 32'h1122ccdd);

        cpu_req(32'h00000010, 4'h0, 32'h0);
        check("oor_rdata", rdata, 32'h0);
        check("oor_pulse", {31'h0, oor_err}, 32'h1);
        tick();
        check("oor_drop", {31'h0, oor_err}, 32'h0);
        cpu_req(32'h00000010, 4'hf, 32'hffffffff);
        check("oor_wr_pulse", {31'h0, oor_err}, 32'h1);
        cpu_req(32'hbfc00010, 4'h0, 32'h0);
        check("oor_wr_noeffect", rdata, 32'h0);
        check("hit_no_oor", {31'h0, oor_err}, 32'h0);
        cpu_req(32'hbfc00004, 4'h0, 32'h0);
        check("oor_array_kept", rdata, 32'h1122ccdd);

        load(4'd2, 32'h12345678, 4'b0100);
        cpu_req(32'hbfc00008, 4'h0, 32'h0);
        check("par_rdata", rdata, 32'h12345678);
        check("par_pulse", {31'h0, par_err}, {31'h0, PAR_EXP});
        tick();
        check("par_drop", {31'h0, par_err}, 32'h0);
        cpu_req(32'hbfc00000, 4'h0, 32'h0);
        check("par_clean", {31'h0, par_err}, 32'h0);

        // Back-to-back reads with no idle cycles between them.
        load(4'd3, 32'ha5a5a5a5, 4'h0);
        en = 1'b1; wen = 4'h0;
        addr = 32'hbfc00000; tick(); check("b2b_0", rdata, 32'h3c1d0001);
        addr = 32'hbfc00004; tick(); check("b2b_1", rdata, 32'h1122ccdd);
        addr = 32'hbfc0000c; tick(); check("b2b_3", rdata, 32'ha5a5a5a5);
        en = 1'b0;

        // Loader and CPU write hit the same word: loader wins, CPU sees old data.
        ld_en = 1'b1; ld_idx = 4'd5; ld_data = 32'h55667788;
        cpu_req(32'hbfc00014, 4'hf, 32'hdeadbeef);
        ld_en = 1'b0;
        check("ld_vs_wr_old", rdata, 32'h0);
        cpu_req(32'hbfc00014, 4'h0, 32'h0);
        check("ld_wins", rdata, 32'h55667788);

        // Loader and CPU read of the same word: read returns pre-load data.
        ld_en = 1'b1; ld_idx = 4'd0; ld_data = 32'h0badf00d;
        cpu_req(32'hbfc00000, 4'h0, 32'h0);
        ld_en = 1'b0;
        check("ld_vs_rd_old", rdata, 32'h3c1d0001);
        cpu_req(32'hbfc00000, 4'h0, 32'h0);
        check("ld_vs_rd_new", rdata, 32'h0badf00d);

        // Reset in the middle of the sweep, with requests and loads held active.
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        #2 resetn = 1'b0;
        #1;
        check("mid_rst_init", {31'h0, init_done}, 32'h0);
        check("mid_rst_rdata", rdata, 32'h0);
        tick();
        en = 1'b1; wen = 4'h0; addr = 32'h00000010;
        ld_en = 1'b1; ld_idx = 4'd6; ld_data = 32'hcafef00d;
        resetn = 1'b1;
        wait_init("reclear");
        en = 1'b0; ld_en = 1'b0;
        check("reclear_oor", {31'h0, oor_err}, 32'h0);
        cpu_req(32'hbfc00000, 4'h0, 32'h0);
        check("reclear_w0", rdata, 32'h0);
        cpu_req(32'hbfc00018, 4'h0, 32'h0);
        check("reclear_ld_ignored", rdata, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
